// File: rtl/alu_exec_unit_if.sv
// Sequencer handshake plus register-group port bundle for the execute stage.
// The slave side is the execute unit; the master side is its environment.
interface alu_exec_unit_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [3:0]       op;
  logic [1:0]       rs;
  logic [1:0]       rd;
  logic [WIDTH-1:0] s_in;
  logic [WIDTH-1:0] d_in;
  logic [1:0]       sr;
  logic [1:0]       dr;
  logic             we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             flag_c;
  logic             flag_z;

  modport master (
    output start, op, rs, rd, s_in, d_in,
    input  sr, dr, we, wdata, busy, done, flag_c, flag_z
  );

  modport slave (
    input  start, op, rs, rd, s_in, d_in,
    output sr, dr, we, wdata, busy, done, flag_c, flag_z
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Multicycle execute stage: reads two registers, computes (or shift-add
// multiplies), writes back to rd and updates the C/Z flags.
//
// state | meaning
// IDLE  | waiting for start; sr/dr hold the last latched selects
// READ  | selects driven, operands captured at the posedge
// EXEC  | single-cycle result registered, or multiply setup
// MUL   | one shift-add step per cycle, MUL_STEPS cycles
// WB    | write back when the op writes; flags committed on exit
module alu_exec_unit #(
  parameter int WIDTH     = 8,
  parameter int MUL_STEPS = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_exec_unit_if.slave bus
);
  localparam int MCW = $clog2(MUL_STEPS);

  localparam logic [3:0] OP_MOV = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_XOR = 4'h5;
  localparam logic [3:0] OP_NOT = 4'h6;
  localparam logic [3:0] OP_SHL = 4'h7;
  localparam logic [3:0] OP_SHR = 4'h8;
  localparam logic [3:0] OP_INC = 4'h9;
  localparam logic [3:0] OP_DEC = 4'hA;
  localparam logic [3:0] OP_MUL = 4'hB;
  localparam logic [3:0] OP_CMP = 4'hC;

  typedef enum logic [2:0] {IDLE, READ, EXEC, MUL, WB} state_t;

  state_t             state, state_nx;
  logic [3:0]         op_q;
  logic [1:0]         sr_q, dr_q;
  logic [WIDTH-1:0]   a_q, b_q, res_q;
  logic [2*WIDTH-1:0] acc_q, acc_nx;
  logic [MCW-1:0]     mcnt_q;
  logic               c_nx_q, z_nx_q;
  logic               flag_c_q, flag_z_q, done_q;
  logic               we_c;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic               op_writes, op_nop, mul_last;

  assign op_writes = (op_q <= OP_MUL);
  assign op_nop    = (op_q > OP_CMP);
  assign mul_last  = (mcnt_q == MCW'(MUL_STEPS - 1));
  assign acc_nx    = acc_q + (b_q[mcnt_q] ? ({{WIDTH{1'b0}}, a_q} << mcnt_q) : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    we_c     = 1'b0;
    unique case (state)
      IDLE: if (bus.start) state_nx = READ;
      READ: state_nx = EXEC;
      EXEC: state_nx = (op_q == OP_MUL) ? MUL : WB;
      MUL:  if (mul_last) state_nx = WB;
      WB: begin
        we_c     = op_writes;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    unique case (op_q)
      OP_MOV: alu_res = b_q;
      OP_ADD: {alu_c, alu_res} = {1'b0, a_q} + {1'b0, b_q};
      OP_SUB, OP_CMP: begin
        alu_res = a_q - b_q;
        alu_c   = (a_q < b_q);
      end
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_XOR: alu_res = a_q ^ b_q;
      OP_NOT: alu_res = ~a_q;
      OP_SHL: begin
        alu_res = a_q << 1;
        alu_c   = a_q[WIDTH-1];
      end
      OP_SHR: begin
        alu_res = a_q >> 1;
        alu_c   = a_q[0];
      end
      OP_INC: begin
        alu_res = a_q + 1'b1;
        alu_c   = &a_q;
      end
      OP_DEC: begin
        alu_res = a_q - 1'b1;
        alu_c   = ~|a_q;
      end
      default: begin
        alu_res = '0;
        alu_c   = 1'b0;
      end
    endcase
  end

  // Pending flags are held in c_nx_q/z_nx_q so C/Z only move on the WB exit edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      sr_q     <= '0;
      dr_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      acc_q    <= '0;
      mcnt_q   <= '0;
      c_nx_q   <= 1'b0;
      z_nx_q   <= 1'b0;
      flag_c_q <= 1'b0;
      flag_z_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: if (bus.start) begin
          op_q <= bus.op;
          sr_q <= bus.rs;
          dr_q <= bus.rd;
        end
        READ: begin
          a_q <= bus.d_in;
          b_q <= bus.s_in;
        end
        EXEC: if (op_q == OP_MUL) begin
          acc_q  <= '0;
          mcnt_q <= '0;
        end else begin
          res_q  <= alu_res;
          c_nx_q <= alu_c;
          z_nx_q <= (alu_res == '0);
        end
        MUL: begin
          acc_q  <= acc_nx;
          mcnt_q <= mcnt_q + 1'b1;
          if (mul_last) begin
            res_q  <= acc_nx[WIDTH-1:0];
            c_nx_q <= |acc_nx[2*WIDTH-1:WIDTH];
            z_nx_q <= (acc_nx[WIDTH-1:0] == '0);
          end
        end
        WB: begin
          done_q <= 1'b1;
          if (!op_nop) begin
            flag_c_q <= c_nx_q;
            flag_z_q <= z_nx_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.sr     = sr_q;
  assign bus.dr     = dr_q;
  assign bus.we     = we_c;
  assign bus.wdata  = res_q;
  assign bus.busy   = (state != IDLE);
  assign bus.done   = done_q;
  assign bus.flag_c = flag_c_q;
  assign bus.flag_z = flag_z_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: register-group model, per-cycle reference model
// compare, and directed vectors with literal expectations.
module tb_alu_exec_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  logic [7:0] rf [4];
  logic       pl_we = 1'b0;
  logic [1:0] pl_idx = '0;
  logic [7:0] pl_val = '0;

  alu_exec_unit_if bus ();
  alu_exec_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // Register group: combinational reads, write at negedge.
  assign bus.s_in = rf[bus.sr];
  assign bus.d_in = rf[bus.dr];
  always @(negedge clk) begin
    if (bus.we) rf[bus.dr] <= bus.wdata;
    if (pl_we)  rf[pl_idx] <= pl_val;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                                output logic wr, output logic [7:0] r, output logic c,
                                output logic nop);
    int t;
    wr = 1'b1; nop = 1'b0; c = 1'b0; r = '0; t = 0;
    case (o)
      4'h0: r = b;
      4'h1: begin t = int'(a) + int'(b); r = 8'(t); c = (t > 255); end
      4'h2, 4'hC: begin
        t = int'(a) - int'(b); r = 8'(t); c = (t < 0); wr = (o == 4'h2);
      end
      4'h3: r = a & b;
      4'h4: r = a | b;
      4'h5: r = a ^ b;
      4'h6: r = 8'(255 - int'(a));
      4'h7: begin t = int'(a) * 2; r = 8'(t); c = (t > 255); end
      4'h8: begin r = 8'(int'(a) / 2); c = ((int'(a) % 2) == 1); end
      4'h9: begin t = int'(a) + 1; r = 8'(t); c = (t > 255); end
      4'hA: begin t = int'(a) - 1; r = 8'(t); c = (t < 0); end
      4'hB: begin t = int'(a) * int'(b); r = 8'(t); c = (t > 255); end
      default: begin wr = 1'b0; nop = 1'b1; end
    endcase
  endfunction

  // Reference model and per-cycle compare.
  logic       m_active = 1'b0, m_done = 1'b0, m_wr = 1'b0, m_nop = 1'b0;
  logic       m_c = 1'b0, m_z = 1'b0, m_rc = 1'b0;
  logic [7:0] m_res = '0;
  logic [1:0] m_rs = '0, m_rd = '0;
  int         m_k = 0, m_lat = 0;

  always @(posedge clk) begin
    m_done = 1'b0;
    if (!rst_n) begin
      m_active = 1'b0; m_k = 0; m_c = 1'b0; m_z = 1'b0; m_rs = '0; m_rd = '0;
    end else if (m_active) begin
      m_k++;
      if (m_k == m_lat) begin
        m_active = 1'b0;
        m_done   = 1'b1;
        if (!m_nop) begin
          m_c = m_rc;
          m_z = (m_res == 8'h00);
        end
      end
    end else if (bus.start) begin
      m_active = 1'b1;
      m_k      = 0;
      m_rs     = bus.rs;
      m_rd     = bus.rd;
      m_lat    = (bus.op == 4'hB) ? 11 : 3;
      model(bus.op, rf[bus.rd], rf[bus.rs], m_wr, m_res, m_rc, m_nop);
    end
    #1;
    chk("busy", 32'(bus.busy), 32'(m_active));
    chk("done", 32'(bus.done), 32'(m_done));
    chk("we", 32'(bus.we), 32'(m_active && (m_k == m_lat - 1) && m_wr));
    if (bus.we) chk("wdata", 32'(bus.wdata), 32'(m_res));
    chk("sr", 32'(bus.sr), 32'(m_rs));
    chk("dr", 32'(bus.dr), 32'(m_rd));
    chk("flag_c", 32'(bus.flag_c), 32'(m_c));
    chk("flag_z", 32'(bus.flag_z), 32'(m_z));
    if (m_done && m_wr) chk("rf_write", 32'(rf[m_rd]), 32'(m_res));
  end

  task automatic set_reg(input logic [1:0] idx, input logic [7:0] val);
    pl_idx = idx; pl_val = val; pl_we = 1'b1;
    @(negedge clk); #1;
    pl_we = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [3:0] o, input logic [1:0] d,
                        input logic [1:0] s, input logic [7:0] er, input logic ec,
                        input logic ez, input int elat);
    int n;
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.rd = d; bus.rs = s;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (n < 20) begin
      @(posedge clk); #2;
      n++;
      if (bus.done) break;
    end
    chk({name, "_latency"}, 32'(n), 32'(elat));
    chk({name, "_reg"}, 32'(rf[d]), 32'(er));
    chk({name, "_c"}, 32'(bus.flag_c), 32'(ec));
    chk({name, "_z"}, 32'(bus.flag_z), 32'(ez));
  endtask

  initial begin
    int n;
    bus.start = 1'b0; bus.op = '0; bus.rs = '0; bus.rd = '0;
    set_reg(2'd0, 8'h01);
    set_reg(2'd1, 8'h00);
    set_reg(2'd2, 8'h00);
    set_reg(2'd3, 8'h07);
    chk("rst_outputs", {bus.sr, bus.dr, bus.we, bus.wdata, bus.busy, bus.done,
                        bus.flag_c, bus.flag_z}, 32'h0);
    @(negedge clk); rst_n = 1'b1;

    run_op("add",  4'h1, 2'd0, 2'd3, 8'h08, 1'b0, 1'b0, 3);
    set_reg(2'd0, 8'h01);
    run_op("sub",  4'h2, 2'd0, 2'd3, 8'hFA, 1'b1, 1'b0, 3);
    run_op("cmp",  4'hC, 2'd3, 2'd3, 8'h07, 1'b0, 1'b1, 3);
    set_reg(2'd0, 8'h25);
    run_op("mul1", 4'hB, 2'd3, 2'd0, 8'h03, 1'b1, 1'b0, 11);
    set_reg(2'd1, 8'h0F); set_reg(2'd2, 8'h03);
    run_op("mul2", 4'hB, 2'd1, 2'd2, 8'h2D, 1'b0, 1'b0, 11);
    set_reg(2'd2, 8'hFF);
    run_op("inc",  4'h9, 2'd2, 2'd2, 8'h00, 1'b1, 1'b1, 3);
    set_reg(2'd2, 8'h81);
    run_op("shl",  4'h7, 2'd2, 2'd0, 8'h02, 1'b1, 1'b0, 3);
    set_reg(2'd2, 8'h01);
    run_op("shr",  4'h8, 2'd2, 2'd2, 8'h00, 1'b1, 1'b1, 3);
    run_op("nop",  4'hD, 2'd2, 2'd1, 8'h00, 1'b1, 1'b1, 3);
    run_op("mov",  4'h0, 2'd1, 2'd0, 8'h25, 1'b0, 1'b0, 3);
    run_op("and",  4'h3, 2'd1, 2'd3, 8'h01, 1'b0, 1'b0, 3);
    set_reg(2'd1, 8'hF0);
    run_op("or",   4'h4, 2'd1, 2'd3, 8'hF3, 1'b0, 1'b0, 3);
    run_op("xor",  4'h5, 2'd1, 2'd1, 8'h00, 1'b0, 1'b1, 3);
    run_op("not",  4'h6, 2'd1, 2'd0, 8'hFF, 1'b0, 1'b0, 3);
    run_op("dec",  4'hA, 2'd2, 2'd2, 8'hFF, 1'b1, 1'b0, 3);
    run_op("addc", 4'h1, 2'd1, 2'd2, 8'hFE, 1'b1, 1'b0, 3);
    set_reg(2'd0, 8'h05);
    run_op("subz", 4'h2, 2'd0, 2'd0, 8'h00, 1'b0, 1'b1, 3);

    // start pulsed while busy must be ignored
    set_reg(2'd1, 8'h03); set_reg(2'd2, 8'h04);
    @(negedge clk); bus.start = 1'b1; bus.op = 4'hB; bus.rd = 2'd1; bus.rs = 2'd2;
    @(negedge clk); bus.start = 1'b0;
    repeat (3) @(negedge clk);
    bus.start = 1'b1; bus.op = 4'h1; bus.rd = 2'd2; bus.rs = 2'd2;
    @(negedge clk); bus.start = 1'b0;
    n = 0;
    repeat (16) begin @(posedge clk); #2; if (bus.done) n++; end
    chk("pulse_dones", 32'(n), 32'd1);
    chk("pulse_reg", 32'(rf[1]), 32'h0C);

    // start held high: back-to-back INCs, accept in the cycle after each done
    set_reg(2'd1, 8'h00);
    @(negedge clk); bus.start = 1'b1; bus.op = 4'h9; bus.rd = 2'd1; bus.rs = 2'd1;
    n = 0;
    repeat (12) begin @(posedge clk); #2; if (bus.done) n++; end
    @(negedge clk); bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("held_dones", 32'(n), 32'd3);
    chk("held_reg", 32'(rf[1]), 32'h03);

    // reset inside WB, before the register group's negedge capture
    set_reg(2'd2, 8'hFF);
    run_op("inc2", 4'h9, 2'd2, 2'd2, 8'h00, 1'b1, 1'b1, 3);
    set_reg(2'd2, 8'h10); set_reg(2'd1, 8'h05);
    @(negedge clk); bus.start = 1'b1; bus.op = 4'h1; bus.rd = 2'd2; bus.rs = 2'd1;
    @(negedge clk); bus.start = 1'b0;
    n = 0;
    while (bus.we !== 1'b1 && n < 20) begin @(posedge clk); #2; n++; end
    chk("wb_reached", 32'(n), 32'd2);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_we", 32'(bus.we), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_flags", {bus.flag_c, bus.flag_z, bus.done}, 32'd0);
    @(negedge clk); #1;
    chk("rst_no_write", 32'(rf[2]), 32'h10);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    run_op("post_rst", 4'h1, 2'd2, 2'd1, 8'h15, 1'b0, 1'b0, 3);

    repeat (2) @(posedge clk);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end
endmodule

// File: doc/alu_exec_unit.md
Name:
alu_exec_unit

Overview:
- Multicycle execute stage that sits directly downstream of the 4x8-bit register group and feeds its write port back.
- Each operation runs as a small sequence:
  - drives source/destination selects to the register group;
  - latches both operands;
  - computes the result, single-cycle or iterative 8-step multiply;
  - writes the result back through we/dr/i;
  - updates C/Z flags.
- Controlled by a start/busy/done handshake from the sequencer.

Parameters:
- WIDTH, 8, datapath width; fixed at 8 for this machine.
- MUL_STEPS, 8, shift-add iterations for MUL; equals WIDTH.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- op  input  4  opcode, latched on accepted start.
- rs  input  2  source register index, latched.
- rd  input  2  destination register index, latched.
- s_in  input  8  register group s output, R[sr].
- d_in  input  8  register group d output, R[dr].
- sr  output  2  source select to register group.
- dr  output  2  destination select to register group.
- we  output  1  register group write enable.
- wdata  output  8  write data to register group i.
- busy  output  1  high in any state except IDLE.
- done  output  1  one-cycle completion pulse.
- flag_c  output  1  carry/borrow flag.
- flag_z  output  1  zero flag.

Behaviour:
- Reset, asynchronous:
  - state=IDLE;
  - sr, dr, we, wdata, done, flag_c, flag_z, operand latches, multiply counter all 0;
  - we drops immediately, so no write occurs.
- States: IDLE, READ, EXEC, MUL, WB.
- IDLE:
  - start=1 latches op/rs/rd and goes to READ.
  - start outside IDLE is ignored.
- READ:
  - sr=rs, dr=rd.
  - At posedge, A<=d_in and B<=s_in; go to EXEC.
- EXEC:
  - op!=MUL: result and next flags computed combinationally, registered; go to WB.
  - op=MUL: acc=0, mcnt=0; go to MUL.
- MUL:
  - Each cycle: if B[mcnt], acc += A<<mcnt (16-bit); mcnt++.
  - After MUL_STEPS cycles go to WB.
- WB, exactly one cycle:
  - we=1 and wdata=result when op writes; register group captures at negedge within this cycle.
  - Flags update at the posedge leaving WB.
  - Next state IDLE with done=1 for that one cycle.
- sr/dr hold the last latched rs/rd while IDLE. we=0 in every state except WB.
- Latency from start-sampling edge to done high:
  - 3 edges for non-MUL ops;
  - 11 edges for MUL.
  - A new start is accepted in the same cycle that done=1 (state is IDLE).
- Opcodes (A = R[rd], B = R[rs], result to rd):
  - 0 MOV: B; C=0.
  - 1 ADD: A+B; C=carry out.
  - 2 SUB: A-B mod 256; C=1 if A<B.
  - 3 AND, 4 OR, 5 XOR: C=0.
  - 6 NOT: ~A; C=0.
  - 7 SHL: A<<1; C=A[7].
  - 8 SHR: logical A>>1; C=A[0].
  - 9 INC: A+1; C=1 if A==FF.
  - A DEC: A-1; C=1 if A==00.
  - B MUL: low byte of A*B; C=1 if high byte !=0.
  - C CMP: A-B flags as SUB, we stays 0.
  - D-F NOP: we=0, flags unchanged, done still pulses.
- Z = (8-bit result==0) for all ops except NOP.
- rs==rd is legal: A and B both equal that register.
- Reset asserted mid-operation (any state) aborts with no write and no done.

Test Plan:
- Reset with registers R0=01, R3=07: all outputs 0. Then ADD rd=0 rs=3 -> we=1 in WB, wdata=08, R0=08, C=0, Z=0, done pulses 3 edges after start.
- SUB rd=0 rs=3 with R0=01, R3=07 -> R0=FA, C=1, Z=0. Then CMP rd=3 rs=3 -> no write (we never 1), Z=1, C=0.
- MUL rd=3 rs=0 with R3=07, R0=25h -> R3=03h (0x103 low byte), C=1; busy high for 11 cycles, done on 11th edge. Then MUL of 0x0F*0x03 -> 2D, C=0.
- INC on R=FF -> 00, C=1, Z=1. SHL on 81 -> 02, C=1. SHR on 01 -> 00, C=1, Z=1.
- Start pulsed while busy -> ignored, single done. Start held high continuously -> back-to-back ops with done and next accept on the same cycle.
- rst_n driven low during WB before negedge -> we drops asynchronously, destination register unchanged, done never asserted, flags 0.
